// File: rtl/cross_bar_pkg.sv
// Shared types and default widths for the crossbar egress-port arbiter.
package cross_bar_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_t;

    localparam int DEF_SSEL_WIDTH = 2;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/cross_bar_port_arbiter_if.sv
// Multi-lane AXI-Stream bundle; LANES = SOURCE_NO on the ingress side, 1 on egress.
interface cross_bar_port_arbiter_if
    import cross_bar_pkg::*;
#(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] tdata [LANES];
    logic [LANES-1:0]      tvalid;
    logic [LANES-1:0]      tlast;
    logic [LANES-1:0]      tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/cross_bar_port_arbiter_rr_priority_encoder.sv
// Round-robin priority search: first requester after last_grant, wrapping modulo SOURCE_NO.
module rr_priority_encoder #(
    parameter int SOURCE_NO  = 4,
    parameter int SSEL_WIDTH = 2
) (
    input  logic [SOURCE_NO-1:0]  req,
    input  logic [SSEL_WIDTH-1:0] last_grant,
    output logic [SSEL_WIDTH-1:0] winner,
    output logic                  any_req
);

    logic [SSEL_WIDTH-1:0] idx;

    // Offsets run 1..SOURCE_NO so last_grant itself is examined last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 1; k <= SOURCE_NO; k++) begin
            idx = SSEL_WIDTH'((int'(last_grant) + k) % SOURCE_NO);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cross_bar_port_arbiter.sv
// Packet-level round-robin arbiter/mux for one crossbar egress port.
// Optional per-source packet counters: define CROSS_BAR_ARB_STATS_EN.
module cross_bar_port_arbiter
    import cross_bar_pkg::*;
#(
    parameter int SSEL_WIDTH = DEF_SSEL_WIDTH,
    parameter int SOURCE_NO  = 2 ** SSEL_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef CROSS_BAR_ARB_STATS_EN
    ,parameter int CNT_WIDTH = DEF_CNT_WIDTH
`endif
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    cross_bar_port_arbiter_if.slave  s_axis,
    cross_bar_port_arbiter_if.master m_axis,
    output logic                    grant_active,
    output logic [SSEL_WIDTH-1:0]   grant_idx
`ifdef CROSS_BAR_ARB_STATS_EN
    ,output logic [CNT_WIDTH-1:0]   pkt_count [SOURCE_NO]
`endif
);

    arb_state_t            state_q, state_d;
    logic [SSEL_WIDTH-1:0] grant_d;
    logic [SSEL_WIDTH-1:0] last_grant;
    logic [SSEL_WIDTH-1:0] winner;
    logic                  any_req;
    logic                  pkt_done;
    logic [DATA_WIDTH-1:0] mux_data;

    rr_priority_encoder #(
        .SOURCE_NO  (SOURCE_NO),
        .SSEL_WIDTH (SSEL_WIDTH)
    ) u_rr_enc (
        .req        (s_axis.tvalid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    // last_grant resets to the top index so source 0 wins the first search.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            grant_idx  <= '0;
            last_grant <= SSEL_WIDTH'(SOURCE_NO - 1);
        end else begin
            state_q   <= state_d;
            grant_idx <= grant_d;
            if (pkt_done) begin
                last_grant <= grant_idx;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_idx;
        pkt_done         = 1'b0;
        mux_data         = s_axis.tdata[grant_idx];
        m_axis.tvalid[0] = 1'b0;
        m_axis.tlast[0]  = 1'b0;
        s_axis.tready    = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = winner;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                m_axis.tvalid[0]         = s_axis.tvalid[grant_idx];
                m_axis.tlast[0]          = s_axis.tlast[grant_idx];
                s_axis.tready[grant_idx] = m_axis.tready[0];
                if (s_axis.tvalid[grant_idx] && m_axis.tready[0] && s_axis.tlast[grant_idx]) begin
                    pkt_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_axis.tdata[0] = mux_data;
    assign grant_active    = (state_q == ACTIVE);

`ifdef CROSS_BAR_ARB_STATS_EN
    // Saturating completed-packet counters; truncated packets never reach pkt_done.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < SOURCE_NO; i++) begin
                pkt_count[i] <= '0;
            end
        end else if (pkt_done && (pkt_count[grant_idx] != '1)) begin
            pkt_count[grant_idx] <= pkt_count[grant_idx] + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
